ldvio_vld_table: RTL and testbench
==================================

Name: ldvio_vld_table

Overview:
- Parametrised successor to the load-violation valid RAM.
- DEPTH-entry table; each entry holds a WIDTH-bit payload and a valid bit.
- Provides RPORT flattened combinational read ports, WPORT write ports, a flash clear, and a wrap-around range clear for squashing on recovery.
- Maintains a registered valid-entry count. Sits beside the LSQ/dispatch path and is read at dispatch width.

Parameters:
- RPORT, 4, number of read ports.
- WPORT, 2, number of write ports.
- DEPTH, 32, number of entries; power of two, at least 2.
- INDEX, 5, address width; equals log2(DEPTH).
- WIDTH, 8, payload bits per entry.
- BYPASS, 0, when 1 reads return the entry's next-state value; when 0 they return the current state.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- rd_addr_i  in  RPORT*INDEX  read addresses; port p uses bits [p*INDEX +: INDEX].
- rd_data_o  out  RPORT*WIDTH  read payloads.
- rd_vld_o  out  RPORT  read valid bits.
- wr_en_i  in  WPORT  write enables.
- wr_addr_i  in  WPORT*INDEX  write addresses.
- wr_data_i  in  WPORT*WIDTH  write payloads; a write sets the entry's valid bit to 1.
- flush_i  in  1  flash clear: all valid bits go to 0.
- clr_en_i  in  1  range clear enable.
- clr_start_i  in  INDEX  first entry of the range, inclusive.
- clr_end_i  in  INDEX  end of the range, exclusive.
- valid_cnt_o  out  INDEX+1  registered count of valid entries.
- full_o  out  1  valid_cnt_o == DEPTH.
- empty_o  out  1  valid_cnt_o == 0.

Behaviour:
- Reset (reset == 0, asynchronous):
  - All valid bits and all payloads go to 0; valid_cnt_o = 0.
  - empty_o = 1, full_o = 0.
  - rd_data_o and rd_vld_o become 0 for every address.
  - Reset mid-operation aborts any pending update; the first edge after release behaves normally.
- Next-state computation, per entry, each cycle (reset deasserted), in priority order high to low:
  1. flush_i = 1: valid = 0; payload is unchanged.
  2. clr_en_i = 1 and the entry is in the range: valid = 0; payload is unchanged.
  3. Any write port targets the entry: valid = 1, payload = wr_data of the highest-indexed enabled port targeting it.
  4. Otherwise the entry holds its value.
- Squash dominates allocation: a same-cycle write into a cleared entry is dropped entirely, payload included.
- Range membership, with s = clr_start_i, e = clr_end_i, i = entry index:
  - s < e: s <= i < e.
  - s > e (wrap-around): i >= s or i < e.
  - s == e: the range is empty and nothing is cleared. Callers use flush_i to clear everything.
- Reads are combinational, zero latency, and all ports are independent.
  - BYPASS = 0: a read returns the registered state; a same-cycle write becomes visible next cycle.
  - BYPASS = 1: a read returns the next-state value defined above, so a same-cycle write is visible and a same-cycle clear shows vld = 0.
- Valid count:
  - valid_cnt_o is updated on the same edge as the table and equals the popcount of the next-state valid bits.
  - It is never computed incrementally, so duplicate-address writes and rewrites of already-valid entries do not double count.
  - full_o and empty_o are decoded from the registered valid_cnt_o.
- No back-pressure: writes are always accepted. Writing a valid entry overwrites it, with no error flag.

Test Plan:
- Reset then writes: DEPTH=32. Assert reset low, release. Write addr 3 = 0xA5 (port 0) and addr 7 = 0x3C (port 1) in the same cycle -> next cycle rd_data/rd_vld at addr 3 = 0xA5/1, addr 7 = 0x3C/1; valid_cnt_o = 2; empty_o = 0.
- Port collision: both ports write addr 5 in one cycle, port 0 = 0x11, port 1 = 0x22 -> addr 5 reads 0x22/1; valid_cnt_o increases by exactly 1.
- Wrap-around range clear: fill all 32 entries (full_o = 1). Clear with s = 30, e = 2 -> entries 30, 31, 0, 1 invalid; valid_cnt_o = 28; full_o = 0. Then clear with s = e = 10 -> no change, valid_cnt_o stays 28.
- Clear beats write: in one cycle write addr 31 = 0x7F and clear s = 30, e = 0 -> entry 31 stays invalid and its payload is not 0x7F; valid_cnt_o unchanged by the write.
- Bypass: with BYPASS = 1, write addr 9 = 0x5A while reading addr 9 -> rd_vld = 1 and rd_data = 0x5A in the same cycle. With BYPASS = 0 the same stimulus shows the old value in that cycle and 0x5A next cycle.
- Flush and async reset: from 20 valid entries, pulse flush_i together with a write to addr 4 -> valid_cnt_o = 0, empty_o = 1. Then assert reset low between clock edges -> outputs go to 0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/ldvio_vld_table.sv
// Multi-ported valid/payload table for load-violation tracking, with flash clear,
// wrap-around range squash and a registered valid-entry count.
module ldvio_vld_table #(
  parameter int RPORT  = 4,
  parameter int WPORT  = 2,
  parameter int DEPTH  = 32,
  parameter int INDEX  = 5,
  parameter int WIDTH  = 8,
  parameter int BYPASS = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [RPORT*INDEX-1:0] rd_addr_i,
  output logic [RPORT*WIDTH-1:0] rd_data_o,
  output logic [RPORT-1:0]       rd_vld_o,
  input  logic [WPORT-1:0]       wr_en_i,
  input  logic [WPORT*INDEX-1:0] wr_addr_i,
  input  logic [WPORT*WIDTH-1:0] wr_data_i,
  input  logic                   flush_i,
  input  logic                   clr_en_i,
  input  logic [INDEX-1:0]       clr_start_i,
  input  logic [INDEX-1:0]       clr_end_i,
  output logic [INDEX:0]         valid_cnt_o,
  output logic                   full_o,
  output logic                   empty_o
);

  logic [DEPTH-1:0] vld_p0;
  logic [DEPTH-1:0] vld_nxt;
  logic [WIDTH-1:0] data_p0  [DEPTH];
  logic [WIDTH-1:0] data_nxt [DEPTH];
  logic [INDEX:0]   cnt_p0;
  logic [INDEX:0]   cnt_nxt;

  // start == end is an empty range; start > end wraps past the top entry
  function automatic logic in_range(input logic [INDEX-1:0] i,
                                    input logic [INDEX-1:0] s,
                                    input logic [INDEX-1:0] e);
    if (s < e)      return (i >= s) && (i < e);
    else if (s > e) return (i >= s) || (i < e);
    else            return 1'b0;
  endfunction

  function automatic logic [INDEX:0] popcount(input logic [DEPTH-1:0] v);
    logic [INDEX:0] n;
    n = '0;
    for (int i = 0; i < DEPTH; i++) n = n + {{INDEX{1'b0}}, v[i]};
    return n;
  endfunction

  // Squash overrides allocation: a cleared entry keeps its old payload too
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      vld_nxt[i]  = vld_p0[i];
      data_nxt[i] = data_p0[i];
      for (int p = 0; p < WPORT; p++) begin
        if (wr_en_i[p] && (wr_addr_i[p*INDEX +: INDEX] == INDEX'(i))) begin
          vld_nxt[i]  = 1'b1;
          data_nxt[i] = wr_data_i[p*WIDTH +: WIDTH];
        end
      end
      if (flush_i || (clr_en_i && in_range(INDEX'(i), clr_start_i, clr_end_i))) begin
        vld_nxt[i]  = 1'b0;
        data_nxt[i] = data_p0[i];
      end
    end
  end

  assign cnt_nxt = popcount(vld_nxt);

  // ---- stage p0: table state and count ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p0 <= '0;
      cnt_p0 <= '0;
      for (int i = 0; i < DEPTH; i++) data_p0[i] <= '0;
    end else begin
      vld_p0 <= vld_nxt;
      cnt_p0 <= cnt_nxt;
      for (int i = 0; i < DEPTH; i++) data_p0[i] <= data_nxt[i];
    end
  end

  // Reads are gated by reset so the bypass path also reads zero while held
  for (genvar p = 0; p < RPORT; p++) begin : g_rd
    logic [INDEX-1:0] addr;
    assign addr = rd_addr_i[p*INDEX +: INDEX];
    if (BYPASS != 0) begin : g_byp
      assign rd_vld_o[p]              = reset & vld_nxt[addr];
      assign rd_data_o[p*WIDTH +: WIDTH] = reset ? data_nxt[addr] : '0;
    end else begin : g_reg
      assign rd_vld_o[p]              = reset & vld_p0[addr];
      assign rd_data_o[p*WIDTH +: WIDTH] = reset ? data_p0[addr] : '0;
    end
  end

  assign valid_cnt_o = cnt_p0;
  assign full_o      = (cnt_p0 == (INDEX+1)'(DEPTH));
  assign empty_o     = (cnt_p0 == '0);

endmodule

// File: tb/tb_ldvio_vld_table.sv
// Bench for ldvio_vld_table: registered-read and bypass instances share stimulus
// and are compared against a range-walking reference model.
module tb_ldvio_vld_table;
  localparam int RP = 4, WP = 2, D = 32, IX = 5, W = 8;

  logic clk, reset;
  logic [RP*IX-1:0] rd_addr;
  logic [RP*W-1:0]  rd_data0, rd_data1;
  logic [RP-1:0]    rd_vld0, rd_vld1;
  logic [WP-1:0]    wr_en;
  logic [WP*IX-1:0] wr_addr;
  logic [WP*W-1:0]  wr_data;
  logic             flush, clr_en;
  logic [IX-1:0]    clr_s, clr_e;
  logic [IX:0]      cnt0, cnt1;
  logic             full0, full1, empty0, empty1;

  int passed = 0;
  int total  = 0;

  logic [D-1:0] mv, nv;
  logic [W-1:0] md [D];
  logic [W-1:0] nd [D];

  ldvio_vld_table #(.RPORT(RP), .WPORT(WP), .DEPTH(D), .INDEX(IX), .WIDTH(W), .BYPASS(0)) dut0 (
    .clk(clk), .reset(reset), .rd_addr_i(rd_addr), .rd_data_o(rd_data0), .rd_vld_o(rd_vld0),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .flush_i(flush),
    .clr_en_i(clr_en), .clr_start_i(clr_s), .clr_end_i(clr_e),
    .valid_cnt_o(cnt0), .full_o(full0), .empty_o(empty0));

  ldvio_vld_table #(.RPORT(RP), .WPORT(WP), .DEPTH(D), .INDEX(IX), .WIDTH(W), .BYPASS(1)) dut1 (
    .clk(clk), .reset(reset), .rd_addr_i(rd_addr), .rd_data_o(rd_data1), .rd_vld_o(rd_vld1),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .flush_i(flush),
    .clr_en_i(clr_en), .clr_start_i(clr_s), .clr_end_i(clr_e),
    .valid_cnt_o(cnt1), .full_o(full1), .empty_o(empty1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: apply writes in port order, then walk the clear range, then flush
  task automatic model_next();
    int k;
    nv = mv;
    for (int i = 0; i < D; i++) nd[i] = md[i];
    for (int p = 0; p < WP; p++)
      if (wr_en[p]) begin
        nv[wr_addr[p*IX +: IX]] = 1'b1;
        nd[wr_addr[p*IX +: IX]] = wr_data[p*W +: W];
      end
    if (clr_en) begin
      k = int'(clr_s);
      while (k != int'(clr_e)) begin
        nv[k] = 1'b0;
        nd[k] = md[k];
        k = (k + 1) % D;
      end
    end
    if (flush) begin
      nv = '0;
      for (int i = 0; i < D; i++) nd[i] = md[i];
    end
  endtask

  task automatic check_reads();
    logic [IX-1:0] a;
    model_next();
    for (int p = 0; p < RP; p++) begin
      a = rd_addr[p*IX +: IX];
      chk("rd_vld_reg",  rd_vld0[p],          mv[a]);
      chk("rd_data_reg", rd_data0[p*W +: W],  md[a]);
      chk("rd_vld_byp",  rd_vld1[p],          nv[a]);
      chk("rd_data_byp", rd_data1[p*W +: W],  nd[a]);
    end
  endtask

  task automatic check_counts();
    int n;
    n = 0;
    for (int i = 0; i < D; i++) n += mv[i];
    chk("cnt_reg",   cnt0,   n);
    chk("cnt_byp",   cnt1,   n);
    chk("full_reg",  full0,  n == D);
    chk("empty_reg", empty0, n == 0);
    chk("full_byp",  full1,  n == D);
    chk("empty_byp", empty1, n == 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_vld_reg"}, rd_vld0, 0);
    chk({tag, "_vld_byp"}, rd_vld1, 0);
    chk({tag, "_data_reg"}, rd_data0, 0);
    chk({tag, "_data_byp"}, rd_data1, 0);
    chk({tag, "_cnt"}, cnt0, 0);
    chk({tag, "_empty"}, empty0, 1);
    chk({tag, "_full"}, full0, 0);
  endtask

  // Checks comb reads before the edge, advances the model, checks counts after it
  task automatic tick();
    #1;
    check_reads();
    @(posedge clk);
    mv = nv;
    for (int i = 0; i < D; i++) md[i] = nd[i];
    #1;
    check_counts();
    wr_en = '0; flush = 1'b0; clr_en = 1'b0;
  endtask

  task automatic rand_inputs();
    wr_en   = WP'($urandom_range(0, 3));
    wr_addr = (WP*IX)'($urandom);
    wr_data = (WP*W)'($urandom);
    flush   = ($urandom_range(0, 15) == 0);
    clr_en  = ($urandom_range(0, 3) == 0);
    clr_s   = IX'($urandom);
    clr_e   = IX'($urandom);
    rd_addr = (RP*IX)'($urandom);
  endtask

  initial begin
    reset = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0; flush = 1'b0;
    clr_en = 1'b0; clr_s = '0; clr_e = '0; rd_addr = 20'h1_8C43;
    mv = '0;
    for (int i = 0; i < D; i++) md[i] = '0;

    #3;
    check_reset_outputs("reset");
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Two ports write distinct entries
    wr_en = 2'b11; wr_addr = {5'd7, 5'd3}; wr_data = {8'h3C, 8'hA5};
    rd_addr = {5'd7, 5'd3, 5'd7, 5'd3};
    tick();
    #1;
    chk("t1_data3", rd_data0[7:0], 8'hA5);
    chk("t1_data7", rd_data0[15:8], 8'h3C);
    chk("t1_cnt", cnt0, 2);
    chk("t1_empty", empty0, 0);

    // Collision: higher port wins, counted once
    wr_en = 2'b11; wr_addr = {5'd5, 5'd5}; wr_data = {8'h22, 8'h11};
    rd_addr = {4{5'd5}};
    tick();
    #1;
    chk("t2_data5", rd_data0[7:0], 8'h22);
    chk("t2_cnt", cnt0, 3);

    // Fill every entry; payloads keep bit 7 set so none equals 0x7F
    for (int k = 0; k < D; k += 2) begin
      wr_en = 2'b11; wr_addr = {5'(k + 1), 5'(k)};
      wr_data = {8'h80 | 8'(k + 1), 8'h80 | 8'(k)};
      rd_addr = (RP*IX)'($urandom);
      tick();
    end
    chk("t3_full", full0, 1);

    clr_en = 1'b1; clr_s = 5'd30; clr_e = 5'd2;
    rd_addr = {5'd1, 5'd0, 5'd31, 5'd30};
    tick();
    chk("t3_wrap_cnt", cnt0, 28);
    chk("t3_wrap_full", full0, 0);
    clr_en = 1'b1; clr_s = 5'd10; clr_e = 5'd10;
    tick();
    chk("t3_empty_range_cnt", cnt0, 28);

    // Clear beats write on entry 31
    wr_en = 2'b01; wr_addr = {5'd0, 5'd31}; wr_data = {8'h00, 8'h7F};
    clr_en = 1'b1; clr_s = 5'd30; clr_e = 5'd0;
    rd_addr = {4{5'd31}};
    tick();
    #1;
    chk("t4_vld31", rd_vld0[0], 0);
    chk("t4_data31", rd_data0[7:0], 8'h9F);
    chk("t4_cnt", cnt0, 28);

    // Same-cycle write visibility: bypass instance now, registered instance next cycle
    wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {8'h00, 8'h5A};
    rd_addr = {4{5'd9}};
    #1;
    chk("t5_byp_data", rd_data1[7:0], 8'h5A);
    chk("t5_byp_vld", rd_vld1[0], 1);
    chk("t5_reg_old", rd_data0[7:0], 8'h89);
    tick();
    #1;
    chk("t5_reg_new", rd_data0[7:0], 8'h5A);

    // Down to 20 valid, then flush with a concurrent write
    clr_en = 1'b1; clr_s = 5'd22; clr_e = 5'd30;
    tick();
    chk("t6_cnt20", cnt0, 20);
    flush = 1'b1; wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {8'h00, 8'h44};
    rd_addr = {5'd4, 5'd4, 5'd2, 5'd4};
    tick();
    chk("t6_flush_cnt", cnt0, 0);
    chk("t6_flush_empty", empty0, 1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      tick();
    end

    // Populate read targets, then assert reset between edges
    wr_en = 2'b11; wr_addr = {5'd1, 5'd0}; wr_data = {8'hE1, 8'hE0};
    rd_addr = {5'd1, 5'd0, 5'd1, 5'd0};
    tick();
    chk("t7_pre_vld", rd_vld0[0], 1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    mv = '0;
    for (int i = 0; i < D; i++) md[i] = '0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_counts();
    for (int n = 0; n < 50; n++) begin
      rand_inputs();
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
